waveform_scroll_ctrl: RTL

Scrolling sample-history controller for the waveform renderer. It accepts a decimated stream of signed 9-bit samples into a circular RAM. Once per video frame it snapshots the write pointer. While hcount/vcount sweep the active region, it replays the newest WIDTH samples oldest-to-newest (left to right), delivering one sample per pixel column with hcount/vcount delayed to match. It sits between the sampling front end and the waveform renderer's signal_in.

---
 rtl/waveform_scroll_ctrl_pkg.sv | 17 +
 rtl/waveform_sample_ram.sv | 29 ++
 rtl/waveform_scroll_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/waveform_scroll_ctrl_pkg.sv
// Shared definitions for the scrolling waveform history: controller state
// encoding, sample width and display geometry.
package waveform_scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } scroll_state_t;

  localparam int SAMPLE_BITS = 9;

  localparam int DISP_COLS   = 1024;
  localparam int DISP_LINES  = 768;
  localparam int TOTAL_LINES = 806;

endpackage

// File: rtl/waveform_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module waveform_sample_ram
  import waveform_scroll_ctrl_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic                   vclock,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [SAMPLE_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [SAMPLE_BITS-1:0] rdata
);

  logic [SAMPLE_BITS-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge vclock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; sees the pre-write contents on a collision.
  always_ff @(posedge vclock) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/waveform_scroll_ctrl.sv
// Scrolling sample-history controller. Decimated samples are written into a
// circular RAM; once per frame the write pointer is snapshotted and the
// newest WIDTH samples are replayed oldest-to-newest across the columns,
// two cycles behind hcount/vcount.
//
// Handshake: sample_valid is a one-cycle qualifier with no back-pressure.
// A sample presented while freeze is high (or while FROZEN) is dropped.
module waveform_scroll_ctrl
  import waveform_scroll_ctrl_pkg::*;
#(
  parameter int WIDTH      = DISP_COLS,
  parameter int ADDR_BITS  = 10,
  parameter int DECIM      = 1,
  parameter int LATCH_LINE = 800
) (
  input  logic                   vclock,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  input  logic                   freeze,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  output logic [10:0]            hcount_d,
  output logic [9:0]             vcount_d,
  output logic [SAMPLE_BITS-1:0] signal_out,
  output logic [ADDR_BITS-1:0]   wr_ptr,
  output logic                   filled,
  output logic                   frozen,
  output logic [1:0]             state_dbg
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(WIDTH);
  localparam logic [7:0]         DCNT_LAST  = 8'(DECIM - 1);
  localparam logic [11:0]        WIDTH_12   = 12'(WIDTH);

  scroll_state_t state_q, state_d;

  logic [7:0]             dcnt;
  logic [ADDR_BITS:0]     fill_count;
  logic [ADDR_BITS:0]     fill_lat;
  logic [ADDR_BITS-1:0]   base;
  logic                   is_full;
  logic                   accept;
  logic                   we;
  logic                   snap;
  logic [ADDR_BITS-1:0]   raddr;
  logic [SAMPLE_BITS-1:0] rdata;
  logic                   in_range;
  logic                   col_valid;
  logic                   show_p1;
  logic [10:0]            hcount_p1;
  logic [9:0]             vcount_p1;

  assign is_full = (fill_count == FULL_COUNT);
  assign accept  = sample_valid && !freeze && (state_q != ST_FROZEN);
  assign we      = accept && (dcnt == 8'd0) && !reset;
  assign snap    = (vcount == 10'(LATCH_LINE)) && (hcount == 11'd0);

  // State register.
  always_ff @(posedge vclock) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // Next-state logic: freeze overrides, otherwise FILL graduates to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (freeze)       state_d = ST_FROZEN;
        else if (is_full) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (freeze) state_d = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (!freeze) state_d = is_full ? ST_RUN : ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Decimation counter, write pointer and saturating fill count.
  always_ff @(posedge vclock) begin
    if (reset) begin
      dcnt       <= 8'd0;
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (accept) begin
      dcnt <= (dcnt == DCNT_LAST) ? 8'd0 : dcnt + 8'd1;
      if (dcnt == 8'd0) begin
        wr_ptr     <= wr_ptr + ADDR_BITS'(1);
        fill_count <= is_full ? fill_count : fill_count + (ADDR_BITS+1)'(1);
      end
    end
  end

  // Per-frame snapshot of the oldest column's address and the fill level.
  always_ff @(posedge vclock) begin
    if (reset) begin
      base     <= '0;
      fill_lat <= '0;
    end else if (snap) begin
      base     <= wr_ptr;
      fill_lat <= fill_count;
    end
  end

  // Column x maps to base+x; it is shown only once that slot holds data.
  assign raddr     = base + hcount[ADDR_BITS-1:0];
  assign in_range  = hcount < 11'(WIDTH);
  assign col_valid = (12'(hcount) + 12'(fill_lat)) >= WIDTH_12;

  waveform_sample_ram #(
    .DEPTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .vclock (vclock),
    .we     (we),
    .waddr  (wr_ptr),
    .wdata  (sample_in),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  // Two-stage delay matching the RAM read, masking invalid columns at the end.
  always_ff @(posedge vclock) begin
    if (reset) begin
      hcount_p1  <= '0;
      vcount_p1  <= '0;
      show_p1    <= 1'b0;
      hcount_d   <= '0;
      vcount_d   <= '0;
      signal_out <= '0;
    end else begin
      hcount_p1  <= hcount;
      vcount_p1  <= vcount;
      show_p1    <= in_range && col_valid;
      hcount_d   <= hcount_p1;
      vcount_d   <= vcount_p1;
      signal_out <= show_p1 ? rdata : '0;
    end
  end

  assign filled    = is_full;
  assign frozen    = (state_q == ST_FROZEN);
  assign state_dbg = state_q;

endmodule
